// File: rtl/line_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : line_sram_arbiter
// Purpose  : Shares one single-port line SRAM (1-clk read latency) between a
//            posted write stream (line capture, through a small FIFO) and a
//            req/gnt read port (output/scaler fetch). Writes normally win.
//            A burst limit forces a read through after MAX_WR_BURST writes
//            have been issued while a read was waiting.
// Ports    : clk, rstn (sync, active-low)
//            i_wr_req/i_wr_addr/i_wr_data -> o_wr_gnt, o_wr_drop
//            i_rd_req/i_rd_addr           -> o_rd_gnt, o_rd_valid, o_rd_data
//            o_wbuf_lvl                   posted-write FIFO occupancy
//            o_cs/o_we/o_addr/o_din, i_dout  SRAM side
// Revision : 1.0  initial release
// ============================================================================
module line_sram_arbiter #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 30,
  parameter int WBUF_DEPTH   = 4,
  parameter int MAX_WR_BURST = 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_wr_req,
  input  logic [ADDR_WIDTH-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0]         i_wr_data,
  output logic                          o_wr_gnt,
  output logic                          o_wr_drop,
  input  logic                          i_rd_req,
  input  logic [ADDR_WIDTH-1:0]         i_rd_addr,
  output logic                          o_rd_gnt,
  output logic                          o_rd_valid,
  output logic [DATA_WIDTH-1:0]         o_rd_data,
  output logic [$clog2(WBUF_DEPTH):0]   o_wbuf_lvl,
  output logic                          o_cs,
  output logic                          o_we,
  output logic [ADDR_WIDTH-1:0]         o_addr,
  output logic [DATA_WIDTH-1:0]         o_din,
  input  logic [DATA_WIDTH-1:0]         i_dout
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(MAX_WR_BURST + 1);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(WBUF_DEPTH);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_WR_BURST);

  typedef enum logic [0:0] {
    WR_PRIO  = 1'b0,
    RD_FORCE = 1'b1
  } state_t;

  // posted-write FIFO storage and pointers
  logic [ADDR_WIDTH-1:0] fifo_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [WBUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      wbuf_cnt;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      starve_cnt;
  logic [CNT_W-1:0]      starve_next;
  logic                  rd_valid_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  hz_hit;
  logic                  hz;
  logic                  do_wr;
  logic                  do_rd;

  assign fifo_full  = (wbuf_cnt == DEPTH_LVL);
  assign fifo_empty = (wbuf_cnt == '0);
  assign push       = rstn && i_wr_req && !fifo_full;
  assign pop        = do_wr;

  // Address hazard against entries already in the FIFO. A write pushed in
  // this same cycle is not yet an entry, so it is ordered after the read.
  always_comb begin
    hz_hit = 1'b0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      if ((LVL_W'(k) < wbuf_cnt) &&
          (fifo_addr[rd_ptr + PTR_W'(k)] == i_rd_addr)) begin
        hz_hit = 1'b1;
      end
    end
  end

  assign hz = i_rd_req && hz_hit;

  // Arbitration / next-state
  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    do_wr       = 1'b0;
    do_rd       = 1'b0;
    case (state)
      WR_PRIO: begin
        if (fifo_empty && i_rd_req) begin
          do_rd       = 1'b1;
          starve_next = '0;
        end else if (!fifo_empty) begin
          do_wr = 1'b1;
          if (i_rd_req) begin
            if (starve_cnt != BURST_MAX) begin
              starve_next = starve_cnt + CNT_W'(1);
            end
            if (starve_next == BURST_MAX) begin
              state_next = RD_FORCE;
            end
          end else begin
            starve_next = '0;
          end
        end else begin
          starve_next = '0;
        end
      end
      RD_FORCE: begin
        if (!i_rd_req) begin
          // requester went away: back to normal priority, keep draining
          state_next  = WR_PRIO;
          starve_next = '0;
          do_wr       = !fifo_empty;
        end else if (!hz) begin
          do_rd       = 1'b1;
          starve_next = '0;
          state_next  = WR_PRIO;
        end else begin
          // hazard implies a matching entry, so the FIFO is non-empty
          do_wr = 1'b1;
        end
      end
      default: begin
        state_next  = WR_PRIO;
        starve_next = '0;
      end
    endcase
    if (!rstn) begin
      do_wr = 1'b0;
      do_rd = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= WR_PRIO;
      starve_cnt <= '0;
      rd_valid_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wbuf_cnt   <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      rd_valid_q <= do_rd;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   wbuf_cnt <= wbuf_cnt + LVL_W'(1);
        2'b01:   wbuf_cnt <= wbuf_cnt - LVL_W'(1);
        default: wbuf_cnt <= wbuf_cnt;
      endcase
    end
  end

  // FIFO payload needs no reset; validity is carried by the pointers/count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= i_wr_addr;
      fifo_data[wr_ptr] <= i_wr_data;
    end
  end

  assign o_wr_gnt   = rstn && !fifo_full;
  assign o_wr_drop  = rstn && i_wr_req && fifo_full;
  assign o_rd_gnt   = do_rd;
  assign o_rd_valid = rstn && rd_valid_q;
  assign o_rd_data  = o_rd_valid ? i_dout : '0;
  assign o_wbuf_lvl = rstn ? wbuf_cnt : '0;

  assign o_cs   = do_wr || do_rd;
  assign o_we   = do_wr;
  assign o_addr = do_wr ? fifo_addr[rd_ptr] : (do_rd ? i_rd_addr : '0);
  assign o_din  = do_wr ? fifo_data[rd_ptr] : '0;

endmodule
`default_nettype wire
